// File: rtl/eth_idma_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | eth_idma_pkg                                                                |
// | Shared register map, FSM encoding and bus types for the eth iDMA frontend.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package eth_idma_pkg;

   localparam logic [31:0] REG_MAC_LO    = 32'h00;
   localparam logic [31:0] REG_MAC_HI    = 32'h04;
   localparam logic [31:0] REG_SRC_ADDR  = 32'h10;
   localparam logic [31:0] REG_DST_ADDR  = 32'h14;
   localparam logic [31:0] REG_LENGTH    = 32'h18;
   localparam logic [31:0] REG_SRC_PROT  = 32'h1c;
   localparam logic [31:0] REG_DST_PROT  = 32'h20;
   localparam logic [31:0] REG_REQ_VALID = 32'h38;
   localparam logic [31:0] REG_REQ_READY = 32'h3c;
   localparam logic [31:0] REG_RSP_READY = 32'h40;
   localparam logic [31:0] REG_STATUS    = 32'h44;
   localparam logic [31:0] REG_DONE_CNT  = 32'h48;

   // Bit positions within the one-hot register select vector.
   localparam int unsigned SEL_MAC_LO    = 0;
   localparam int unsigned SEL_MAC_HI    = 1;
   localparam int unsigned SEL_SRC_ADDR  = 2;
   localparam int unsigned SEL_DST_ADDR  = 3;
   localparam int unsigned SEL_LENGTH    = 4;
   localparam int unsigned SEL_SRC_PROT  = 5;
   localparam int unsigned SEL_DST_PROT  = 6;
   localparam int unsigned SEL_REQ_VALID = 7;
   localparam int unsigned SEL_REQ_READY = 8;
   localparam int unsigned SEL_RSP_READY = 9;
   localparam int unsigned SEL_STATUS    = 10;
   localparam int unsigned SEL_DONE_CNT  = 11;
   localparam int unsigned NUM_REGS      = 12;

   typedef enum logic [1:0] {
      FE_IDLE     = 2'd0,
      FE_PENDING  = 2'd1,
      FE_INFLIGHT = 2'd2
   } eth_idma_fe_state_e;

   localparam logic [2:0] PROT_AXI  = 3'd0;
   localparam logic [2:0] PROT_AXIS = 3'd5;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } eth_reg_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } eth_reg_rsp_t;

   function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/eth_idma_reg_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | eth_idma_reg_decode                                                         |
// | Address decode: one-hot register select, unmapped and read-only flags.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module eth_idma_reg_decode
   import eth_idma_pkg::*;
(
   input  logic [31:0]         addr_i,
   output logic [NUM_REGS-1:0] sel_o,
   output logic                unmapped_o,
   output logic                read_only_o
);

   always_comb begin
      sel_o      = '0;
      unmapped_o = 1'b0;
      case (addr_i)
         REG_MAC_LO:    sel_o[SEL_MAC_LO]    = 1'b1;
         REG_MAC_HI:    sel_o[SEL_MAC_HI]    = 1'b1;
         REG_SRC_ADDR:  sel_o[SEL_SRC_ADDR]  = 1'b1;
         REG_DST_ADDR:  sel_o[SEL_DST_ADDR]  = 1'b1;
         REG_LENGTH:    sel_o[SEL_LENGTH]    = 1'b1;
         REG_SRC_PROT:  sel_o[SEL_SRC_PROT]  = 1'b1;
         REG_DST_PROT:  sel_o[SEL_DST_PROT]  = 1'b1;
         REG_REQ_VALID: sel_o[SEL_REQ_VALID] = 1'b1;
         REG_REQ_READY: sel_o[SEL_REQ_READY] = 1'b1;
         REG_RSP_READY: sel_o[SEL_RSP_READY] = 1'b1;
         REG_STATUS:    sel_o[SEL_STATUS]    = 1'b1;
         REG_DONE_CNT:  sel_o[SEL_DONE_CNT]  = 1'b1;
         // Misaligned addresses never match an entry and land here too.
         default:       unmapped_o           = 1'b1;
      endcase
   end

   assign read_only_o = sel_o[SEL_REQ_READY] | sel_o[SEL_STATUS] | sel_o[SEL_DONE_CNT];

endmodule
`default_nettype wire

// File: rtl/eth_idma_reg_frontend.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | eth_idma_reg_frontend                                                       |
// | REG_BUS responder holding MAC config and one iDMA descriptor + launch FSM.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module eth_idma_reg_frontend
   import eth_idma_pkg::*;
#(
   parameter int unsigned AddrWidth   = 64,
   parameter int unsigned TFLenWidth  = 32,
   parameter type         reg_req_t   = eth_idma_pkg::eth_reg_req_t,
   parameter type         reg_rsp_t   = eth_idma_pkg::eth_reg_rsp_t
)(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  reg_req_t              reg_req_i,
   output reg_rsp_t              reg_rsp_o,
   output logic [47:0]           mac_addr_o,
   output logic [15:0]           mac_cfg_o,
   output logic [AddrWidth-1:0]  src_addr_o,
   output logic [AddrWidth-1:0]  dst_addr_o,
   output logic [TFLenWidth-1:0] length_o,
   output logic [2:0]            src_protocol_o,
   output logic [2:0]            dst_protocol_o,
   output logic                  idma_req_valid_o,
   input  logic                  idma_req_ready_i,
   input  logic                  idma_rsp_valid_i,
   output logic                  idma_rsp_ready_o,
   input  logic                  idma_rsp_error_i,
   output logic                  busy_o
);

   localparam logic [1:0] ST_IDLE     = 2'(FE_IDLE);
   localparam logic [1:0] ST_PENDING  = 2'(FE_PENDING);
   localparam logic [1:0] ST_INFLIGHT = 2'(FE_INFLIGHT);

   logic [NUM_REGS-1:0] sel;
   logic                unmapped;
   logic                read_only;

   eth_idma_reg_decode u_decode (
      .addr_i      (reg_req_i.addr),
      .sel_o       (sel),
      .unmapped_o  (unmapped),
      .read_only_o (read_only)
   );

   logic [31:0] mac_lo_q, mac_hi_q;
   logic [31:0] src_q, dst_q, len_q, sprot_q, dprot_q;
   logic        rsp_ready_q;
   logic        err_q;
   logic [31:0] done_cnt_q;
   logic [1:0]  state_q, state_d;

   logic wr_en, desc_sel, desc_locked, reqv_wr, rsp_hs;

   assign wr_en       = reg_req_i.valid & reg_req_i.write & ~unmapped;
   assign desc_sel    = sel[SEL_SRC_ADDR] | sel[SEL_DST_ADDR] | sel[SEL_LENGTH]
                      | sel[SEL_SRC_PROT] | sel[SEL_DST_PROT];
   assign desc_locked = (state_q != ST_IDLE);
   assign reqv_wr     = wr_en & sel[SEL_REQ_VALID] & reg_req_i.wstrb[0];
   assign rsp_hs      = (state_q == ST_INFLIGHT) & idma_rsp_valid_i & rsp_ready_q;

   // A handshake in PENDING takes priority over a simultaneous abort write.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (reqv_wr && reg_req_i.wdata[0]) state_d = ST_PENDING;
         end
         ST_PENDING: begin
            if (idma_req_ready_i)                   state_d = ST_INFLIGHT;
            else if (reqv_wr && !reg_req_i.wdata[0]) state_d = ST_IDLE;
         end
         ST_INFLIGHT: begin
            if (rsp_hs) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mac_lo_q    <= '0;
         mac_hi_q    <= '0;
         src_q       <= '0;
         dst_q       <= '0;
         len_q       <= '0;
         sprot_q     <= '0;
         dprot_q     <= '0;
         rsp_ready_q <= 1'b0;
         err_q       <= 1'b0;
         done_cnt_q  <= '0;
         state_q     <= ST_IDLE;
      end else begin
         state_q <= state_d;
         if (wr_en && sel[SEL_MAC_LO])
            mac_lo_q <= apply_strb(mac_lo_q, reg_req_i.wdata, reg_req_i.wstrb);
         if (wr_en && sel[SEL_MAC_HI])
            mac_hi_q <= apply_strb(mac_hi_q, reg_req_i.wdata, reg_req_i.wstrb);
         if (wr_en && !desc_locked) begin
            if (sel[SEL_SRC_ADDR]) src_q   <= apply_strb(src_q, reg_req_i.wdata, reg_req_i.wstrb);
            if (sel[SEL_DST_ADDR]) dst_q   <= apply_strb(dst_q, reg_req_i.wdata, reg_req_i.wstrb);
            if (sel[SEL_LENGTH])   len_q   <= apply_strb(len_q, reg_req_i.wdata, reg_req_i.wstrb);
            if (sel[SEL_SRC_PROT]) sprot_q <= apply_strb(sprot_q, reg_req_i.wdata, reg_req_i.wstrb);
            if (sel[SEL_DST_PROT]) dprot_q <= apply_strb(dprot_q, reg_req_i.wdata, reg_req_i.wstrb);
         end
         if (wr_en && sel[SEL_RSP_READY] && reg_req_i.wstrb[0])
            rsp_ready_q <= reg_req_i.wdata[0];
         if (rsp_hs) begin
            err_q      <= idma_rsp_error_i;
            done_cnt_q <= done_cnt_q + 32'd1;
         end
      end
   end

   logic [31:0] status;
   logic [31:0] rdata;

   assign status = {27'd0, state_q, err_q, busy_o, idma_rsp_valid_i};

   // Unmapped addresses leave every select low, so rdata falls to zero.
   assign rdata = ({32{sel[SEL_MAC_LO]}}    & mac_lo_q)
                | ({32{sel[SEL_MAC_HI]}}    & mac_hi_q)
                | ({32{sel[SEL_SRC_ADDR]}}  & src_q)
                | ({32{sel[SEL_DST_ADDR]}}  & dst_q)
                | ({32{sel[SEL_LENGTH]}}    & len_q)
                | ({32{sel[SEL_SRC_PROT]}}  & sprot_q)
                | ({32{sel[SEL_DST_PROT]}}  & dprot_q)
                | ({32{sel[SEL_REQ_VALID]}} & {31'd0, idma_req_valid_o})
                | ({32{sel[SEL_REQ_READY]}} & {31'd0, idma_req_ready_i})
                | ({32{sel[SEL_RSP_READY]}} & {31'd0, rsp_ready_q})
                | ({32{sel[SEL_STATUS]}}    & status)
                | ({32{sel[SEL_DONE_CNT]}}  & done_cnt_q);

   always_comb begin
      reg_rsp_o       = '0;
      reg_rsp_o.ready = reg_req_i.valid;
      reg_rsp_o.rdata = rdata;
      reg_rsp_o.error = reg_req_i.valid
                      & (unmapped | (reg_req_i.write & (read_only | (desc_sel & desc_locked))));
   end

   assign mac_addr_o       = {mac_hi_q[15:0], mac_lo_q};
   assign mac_cfg_o        = mac_hi_q[31:16];
   assign src_addr_o       = AddrWidth'(src_q);
   assign dst_addr_o       = AddrWidth'(dst_q);
   assign length_o         = len_q[TFLenWidth-1:0];
   assign src_protocol_o   = sprot_q[2:0];
   assign dst_protocol_o   = dprot_q[2:0];
   assign idma_req_valid_o = (state_q == ST_PENDING);
   assign idma_rsp_ready_o = rsp_ready_q;
   assign busy_o           = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_eth_idma_reg_frontend.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_eth_idma_reg_frontend                                                    |
// | Scoreboard bench for the eth iDMA register frontend.                        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_eth_idma_reg_frontend;
   import eth_idma_pkg::*;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   eth_reg_req_t req;
   eth_reg_rsp_t rsp;
   logic [47:0]  mac_addr;
   logic [15:0]  mac_cfg;
   logic [63:0]  src_addr, dst_addr;
   logic [31:0]  length;
   logic [2:0]   src_prot, dst_prot;
   logic         req_valid, req_ready, rsp_valid, rsp_ready, rsp_error, busy;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] rdata;
      logic        chk_rd;
      logic        err;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   eth_idma_reg_frontend #(.AddrWidth(64), .TFLenWidth(32)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .reg_req_i        (req),
      .reg_rsp_o        (rsp),
      .mac_addr_o       (mac_addr),
      .mac_cfg_o        (mac_cfg),
      .src_addr_o       (src_addr),
      .dst_addr_o       (dst_addr),
      .length_o         (length),
      .src_protocol_o   (src_prot),
      .dst_protocol_o   (dst_prot),
      .idma_req_valid_o (req_valid),
      .idma_req_ready_i (req_ready),
      .idma_rsp_valid_i (rsp_valid),
      .idma_rsp_ready_o (rsp_ready),
      .idma_rsp_error_i (rsp_error),
      .busy_o           (busy)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic void expect_acc(input logic [31:0] a, input logic [31:0] rd,
                                      input logic chk, input logic er);
      exp_t e;
      e.addr = a; e.rdata = rd; e.chk_rd = chk; e.err = er;
      sb_q.push_back(e);
   endfunction

   // Drives one access starting at posedge+1, samples at negedge, returns at posedge+1.
   task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic er);
      req.addr = a; req.write = w; req.wdata = d; req.wstrb = s; req.valid = 1'b1;
      @(negedge clk);
      rd = rsp.rdata;
      er = rsp.error;
      @(posedge clk); #1;
      req.valid = 1'b0; req.write = 1'b0;
   endtask

   // Pops the oldest expectation and compares it with the sampled response.
   task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s);
      logic [31:0] rd;
      logic        er;
      exp_t        e;
      bus(a, w, d, s, rd, er);
      e = sb_q.pop_front();
      checks++;
      if ((e.chk_rd && rd !== e.rdata) || er !== e.err) begin
         failures++;
         $display("FAIL access addr=%h wr=%0b: got rdata=%h err=%b, want rdata=%h err=%b",
                  e.addr, w, rd, er, e.rdata, e.err);
      end
   endtask

   task automatic test_reset;
      logic [31:0] addrs [12];
      addrs = '{32'h00, 32'h04, 32'h10, 32'h14, 32'h18, 32'h1c, 32'h20,
                32'h38, 32'h3c, 32'h40, 32'h44, 32'h48};
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (req_valid !== 1'b0 || rsp_ready !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: got valid=%b rsp_ready=%b busy=%b, want 0 0 0",
                  req_valid, rsp_ready, busy);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      foreach (addrs[i]) expect_acc(addrs[i], 32'h0, 1'b1, 1'b0);
      foreach (addrs[i]) access(addrs[i], 1'b0, 32'h0, 4'h0);
   endtask

   task automatic test_mac;
      expect_acc(32'h00, 32'h0, 1'b0, 1'b0);
      access(32'h00, 1'b1, 32'h98001032, 4'hf);
      expect_acc(32'h04, 32'h0, 1'b0, 1'b0);
      access(32'h04, 1'b1, 32'h00002070, 4'hf);
      checks++;
      if (mac_addr !== 48'h207098001032 || mac_cfg !== 16'h0) begin
         failures++;
         $display("FAIL mac_out: got addr=%h cfg=%h, want 207098001032 0000", mac_addr, mac_cfg);
      end
      // Upper half only: MAC address bytes must survive.
      expect_acc(32'h04, 32'h0, 1'b0, 1'b0);
      access(32'h04, 1'b1, 32'hABCD_FFFF, 4'b1100);
      expect_acc(32'h04, 32'hABCD2070, 1'b1, 1'b0);
      access(32'h04, 1'b0, 32'h0, 4'h0);
      checks++;
      if (mac_addr !== 48'h207098001032 || mac_cfg !== 16'hABCD) begin
         failures++;
         $display("FAIL mac_strb: got addr=%h cfg=%h, want 207098001032 abcd", mac_addr, mac_cfg);
      end
   endtask

   task automatic test_launch;
      int hi_cnt;
      expect_acc(32'h14, 32'h0, 1'b0, 1'b0);
      access(32'h14, 1'b1, 32'hDEADBEEF, 4'hf);
      checks++;
      if (dst_addr !== 64'h00000000DEADBEEF) begin
         failures++;
         $display("FAIL dst_zext: got %h, want 00000000deadbeef", dst_addr);
      end
      expect_acc(32'h10, 32'h0, 1'b0, 1'b0); access(32'h10, 1'b1, 32'h0, 4'hf);
      expect_acc(32'h14, 32'h0, 1'b0, 1'b0); access(32'h14, 1'b1, 32'h0, 4'hf);
      expect_acc(32'h18, 32'h0, 1'b0, 1'b0); access(32'h18, 1'b1, 32'h40, 4'hf);
      expect_acc(32'h1c, 32'h0, 1'b0, 1'b0); access(32'h1c, 1'b1, 32'(PROT_AXI), 4'hf);
      expect_acc(32'h20, 32'h0, 1'b0, 1'b0); access(32'h20, 1'b1, 32'(PROT_AXIS), 4'hf);
      checks++;
      if (src_addr !== 64'h0 || dst_addr !== 64'h0 || length !== 32'h40
          || src_prot !== PROT_AXI || dst_prot !== PROT_AXIS) begin
         failures++;
         $display("FAIL desc_out: got src=%h dst=%h len=%h sp=%0d dp=%0d, want 0 0 40 0 5",
                  src_addr, dst_addr, length, src_prot, dst_prot);
      end
      req_ready = 1'b0;
      expect_acc(32'h38, 32'h0, 1'b0, 1'b0);
      access(32'h38, 1'b1, 32'h1, 4'hf);
      hi_cnt = 0;
      for (int c = 0; c < 5; c++) begin
         if (req_valid === 1'b1) hi_cnt++;
         @(posedge clk); #1;
      end
      checks++;
      if (hi_cnt != 5) begin
         failures++;
         $display("FAIL req_valid_hold: high for %0d cycles, want 5", hi_cnt);
      end
      req_ready = 1'b1;
      @(posedge clk); #1;
      req_ready = 1'b0;
      checks++;
      if (req_valid !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL handshake: got valid=%b busy=%b, want 0 1", req_valid, busy);
      end
      expect_acc(32'h38, 32'h0, 1'b1, 1'b0);  access(32'h38, 1'b0, 32'h0, 4'h0);
      expect_acc(32'h44, 32'h12, 1'b1, 1'b0); access(32'h44, 1'b0, 32'h0, 4'h0);
   endtask

   task automatic test_locked;
      expect_acc(32'h18, 32'h0, 1'b0, 1'b1);
      access(32'h18, 1'b1, 32'h80, 4'hf);
      checks++;
      if (length !== 32'h40) begin
         failures++;
         $display("FAIL desc_lock: got length=%h, want 40", length);
      end
      expect_acc(32'h38, 32'h0, 1'b0, 1'b0);  access(32'h38, 1'b1, 32'h1, 4'hf);
      expect_acc(32'h38, 32'h0, 1'b0, 1'b0);  access(32'h38, 1'b1, 32'h0, 4'hf);
      expect_acc(32'h44, 32'h12, 1'b1, 1'b0); access(32'h44, 1'b0, 32'h0, 4'h0);
   endtask

   task automatic test_complete;
      expect_acc(32'h40, 32'h0, 1'b0, 1'b0);
      access(32'h40, 1'b1, 32'h1, 4'hf);
      checks++;
      if (rsp_ready !== 1'b1) begin
         failures++;
         $display("FAIL rsp_ready: got %b, want 1", rsp_ready);
      end
      rsp_valid = 1'b1; rsp_error = 1'b1;
      @(posedge clk); #1;
      rsp_valid = 1'b0; rsp_error = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL complete_idle: got busy=%b, want 0", busy);
      end
      expect_acc(32'h44, 32'h04, 1'b1, 1'b0); access(32'h44, 1'b0, 32'h0, 4'h0);
      expect_acc(32'h48, 32'h01, 1'b1, 1'b0); access(32'h48, 1'b0, 32'h0, 4'h0);
      expect_acc(32'h40, 32'h01, 1'b1, 1'b0); access(32'h40, 1'b0, 32'h0, 4'h0);
   endtask

   task automatic test_abort;
      expect_acc(32'h38, 32'h0, 1'b0, 1'b0); access(32'h38, 1'b1, 32'h1, 4'hf);
      checks++;
      if (req_valid !== 1'b1) begin
         failures++;
         $display("FAIL abort_launch: got valid=%b, want 1", req_valid);
      end
      expect_acc(32'h38, 32'h0, 1'b0, 1'b0); access(32'h38, 1'b1, 32'h0, 4'hf);
      checks++;
      if (req_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL abort: got valid=%b busy=%b, want 0 0", req_valid, busy);
      end
      expect_acc(32'h48, 32'h01, 1'b1, 1'b0); access(32'h48, 1'b0, 32'h0, 4'h0);
   endtask

   task automatic test_back_to_back;
      expect_acc(32'h38, 32'h0, 1'b0, 1'b0); access(32'h38, 1'b1, 32'h1, 4'hf);
      // Abort write and handshake in the same cycle: handshake wins.
      req_ready = 1'b1;
      expect_acc(32'h38, 32'h0, 1'b0, 1'b0); access(32'h38, 1'b1, 32'h0, 4'hf);
      req_ready = 1'b0;
      expect_acc(32'h44, 32'h16, 1'b1, 1'b0); access(32'h44, 1'b0, 32'h0, 4'h0);
      rsp_valid = 1'b1;
      @(posedge clk); #1;
      rsp_valid = 1'b0;
      expect_acc(32'h44, 32'h00, 1'b1, 1'b0); access(32'h44, 1'b0, 32'h0, 4'h0);
      expect_acc(32'h48, 32'h02, 1'b1, 1'b0); access(32'h48, 1'b0, 32'h0, 4'h0);
   endtask

   task automatic test_errors;
      expect_acc(32'h4c, 32'h0, 1'b1, 1'b1); access(32'h4c, 1'b0, 32'h0, 4'h0);
      expect_acc(32'h02, 32'h0, 1'b1, 1'b1); access(32'h02, 1'b0, 32'h0, 4'h0);
      expect_acc(32'h08, 32'h0, 1'b1, 1'b1); access(32'h08, 1'b0, 32'h0, 4'h0);
      expect_acc(32'h3c, 32'h0, 1'b0, 1'b1); access(32'h3c, 1'b1, 32'h1, 4'hf);
      expect_acc(32'h44, 32'h0, 1'b0, 1'b1); access(32'h44, 1'b1, 32'hff, 4'hf);
      expect_acc(32'h48, 32'h0, 1'b0, 1'b1); access(32'h48, 1'b1, 32'h55, 4'hf);
      expect_acc(32'h48, 32'h2, 1'b1, 1'b0); access(32'h48, 1'b0, 32'h0, 4'h0);
      expect_acc(32'h01, 32'h0, 1'b0, 1'b1); access(32'h01, 1'b1, 32'hffffffff, 4'hf);
      expect_acc(32'h00, 32'h98001032, 1'b1, 1'b0); access(32'h00, 1'b0, 32'h0, 4'h0);
   endtask

   task automatic test_reset_mid;
      expect_acc(32'h38, 32'h0, 1'b0, 1'b0); access(32'h38, 1'b1, 32'h1, 4'hf);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (req_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid: got valid=%b busy=%b, want 0 0", req_valid, busy);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      expect_acc(32'h48, 32'h0, 1'b1, 1'b0); access(32'h48, 1'b0, 32'h0, 4'h0);
      expect_acc(32'h40, 32'h0, 1'b1, 1'b0); access(32'h40, 1'b0, 32'h0, 4'h0);
   endtask

   initial begin
      req       = '0;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_error = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_mac();
      test_launch();
      test_locked();
      test_complete();
      test_abort();
      test_back_to_back();
      test_errors();
      test_reset_mid();
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/eth_idma_reg_frontend.md
# eth_idma_reg_frontend

Register-bus responder for the Ethernet iDMA subsystem. It holds the MAC configuration and the single-transfer descriptor: source, destination, length, and source and destination protocols. It launches the descriptor into the iDMA frontend through a valid/ready handshake and tracks the transfer until the iDMA response is consumed. It sits between the SoC register bus (REG_BUS request/response structs) and `eth_idma_wrap`'s MAC config inputs and iDMA request/response ports.

## Interface
- `AddrWidth`, 64: width of the iDMA source/destination address outputs.
- `TFLenWidth`, 32: width of the transfer length output; must be ≤ 32.
- `reg_req_t`, —: REG_BUS request struct with addr[31:0], write, wdata[31:0], wstrb[3:0], valid.
- `reg_rsp_t`, —: REG_BUS response struct with rdata[31:0], error, ready.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `reg_req_i` in reg_req_t: register access request.
- `reg_rsp_o` out reg_rsp_t: register access response.
- `mac_addr_o` out 48: MAC address; {reg 0x04[15:0], reg 0x00}.
- `mac_cfg_o` out 16: MAC configuration bits, reg 0x04[31:16].
- `src_addr_o` out AddrWidth: reg 0x10, zero-extended.
- `dst_addr_o` out AddrWidth: reg 0x14, zero-extended.
- `length_o` out TFLenWidth: reg 0x18[TFLenWidth-1:0].
- `src_protocol_o` out 3: reg 0x1c[2:0].
- `dst_protocol_o` out 3: reg 0x20[2:0].
- `idma_req_valid_o` out 1: descriptor valid.
- `idma_req_ready_i` in 1: descriptor accepted.
- `idma_rsp_valid_i` in 1: transfer completion valid.
- `idma_rsp_ready_o` out 1: completion accept; reg 0x40[0].
- `idma_rsp_error_i` in 1: completion carries an error.
- `busy_o` out 1: FSM is not IDLE.

## Operation
Register map. All registers are 32 bits wide and the byte strobes `wstrb` are honoured.
- 0x00, 0x04: MAC registers, read/write.
- 0x10, 0x14, 0x18, 0x1c, 0x20: descriptor registers, read/write.
- 0x38 REQ_VALID, read/write bit 0.
- 0x3c REQ_READY, read-only: returns `idma_req_ready_i` in bit 0.
- 0x40 RSP_READY, read/write bit 0.
- 0x44 STATUS, read-only: bit0 `idma_rsp_valid_i`, bit1 `busy_o`, bit2 sticky last error, bits[4:3] FSM state.
- 0x48 DONE_CNT, read-only: 32-bit count of completed transfers, wraps at 2^32.

FSM states:
- IDLE → PENDING: on a write of 1 to REQ_VALID bit 0.
- PENDING → INFLIGHT: on `idma_req_valid_o && idma_req_ready_i`. REQ_VALID clears automatically on the handshake.
- PENDING → IDLE: on a software write of 0 to REQ_VALID before the handshake (abort).
- INFLIGHT → IDLE: on `idma_rsp_valid_i && idma_rsp_ready_o`. The sticky error bit is loaded with `idma_rsp_error_i` and DONE_CNT increments.

Rules:
- `idma_req_valid_o` = (state == PENDING). It stays asserted until the handshake or the abort.
- Descriptor registers (0x10–0x20) are locked outside IDLE. A write to them completes with error=1 and leaves the register unchanged.
- Writes of 1 to REQ_VALID outside IDLE are ignored with error=0. Writes of 0 to REQ_VALID in INFLIGHT are harmless.
- Access to an unmapped or misaligned address (addr[1:0] ≠ 0) completes with error=1 and rdata=0.
- Writes to read-only registers complete with error=1 and have no effect.

## Timing
- Register access latency is zero: `reg_rsp_o.ready` = `reg_req_i.valid` combinationally, and rdata/error are combinational on the address.
- A write takes effect at the next rising edge. A read in the cycle after a write returns the new value.
- The FSM advances one transition per edge. The IDLE→PENDING write and `idma_req_valid_o` assertion occur at the same edge.
- If software writes 0 to REQ_VALID in the same cycle as the iDMA handshake, the handshake wins and the FSM enters INFLIGHT.
- Reset values:
  - All registers, including RSP_READY and DONE_CNT, reset to 0.
  - The FSM resets to IDLE.
  - `idma_req_valid_o`, `idma_rsp_ready_o` and `busy_o` are 0.
- Reset mid-transfer drops the FSM to IDLE immediately. No completion is counted.

## Structure
- The shared `eth_idma_pkg` holds:
  - the register offset localparams;
  - the FSM state enum `eth_idma_fe_state_e` (IDLE=0, PENDING=1, INFLIGHT=2);
  - the protocol encodings (AXI=0, AXIS=5).
- One sub-module, `eth_idma_reg_decode`: combinational address decode producing the one-hot register select plus the unmapped and read-only error flags.
- The FSM, registers and counter live in the top module.

## Test plan
- Reset, then read 0x00–0x48 → all reads return 0 with error=0; `idma_req_valid_o`=0.
- Write 0x00=0x98001032 and 0x04=0x00002070 → `mac_addr_o`=0x207098001032, `mac_cfg_o`=0.
- Program src=0, dst=0, len=0x40, protocols 0/5, then write 0x38=1 with `idma_req_ready_i` low for 5 cycles:
  - `idma_req_valid_o` stays high for 5 cycles;
  - when ready rises, the handshake occurs and the FSM enters INFLIGHT;
  - a read of 0x38 returns 0.
- While INFLIGHT, write 0x18=0x80 → error=1 and `length_o` stays 0x40.
- Write 0x40=1, then pulse `idma_rsp_valid_i` with `idma_rsp_error_i`=1 → FSM returns to IDLE; 0x44 bit2=1; 0x48=1.
- Access 0x4c, 0x02 and a write to 0x3c → error=1; assert `rst_i` during PENDING → `idma_req_valid_o`=0 next cycle.
